// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand select, RAW forwarding from EX/MEM and MEM/WB,
// and a one-cycle load-use bubble. Feeds the ALU's alusel/data1/data2 inputs.
module ex_operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic            I_valid,
  output logic            O_ready,
  input  logic [3:0]      I_alusel,
  input  logic [REGW-1:0] I_rs1,
  input  logic [REGW-1:0] I_rs2,
  input  logic [REGW-1:0] I_rd,
  input  logic            I_wen,
  input  logic            I_is_load,
  input  logic [XLEN-1:0] I_rs1_data,
  input  logic [XLEN-1:0] I_rs2_data,
  input  logic [XLEN-1:0] I_imm,
  input  logic [XLEN-1:0] I_pc,
  input  logic            I_use_imm,
  input  logic            I_use_pc,
  input  logic            I_flush,
  input  logic            I_exmem_valid,
  input  logic            I_exmem_wen,
  input  logic [REGW-1:0] I_exmem_rd,
  input  logic [XLEN-1:0] I_exmem_data,
  input  logic            I_memwb_valid,
  input  logic            I_memwb_wen,
  input  logic [REGW-1:0] I_memwb_rd,
  input  logic [XLEN-1:0] I_memwb_data,
  input  logic            I_ready,
  output logic            O_valid,
  output logic [3:0]      O_alusel,
  output logic [XLEN-1:0] O_data1,
  output logic [XLEN-1:0] O_data2,
  output logic [XLEN-1:0] O_store_data,
  output logic [REGW-1:0] O_rd,
  output logic            O_wen,
  output logic            O_is_load
);

  logic            valid_q, wen_q, is_load_q, use_imm_q, use_pc_q;
  logic [3:0]      alusel_q;
  logic [REGW-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q;

  logic            hazard, accept;
  logic            exmem_hit1, exmem_hit2, memwb_hit1, memwb_hit2, byp_hit1, byp_hit2;
  logic [XLEN-1:0] fwd1, fwd2, cap1, cap2;

  assign hazard = valid_q & is_load_q & wen_q & (rd_q != '0) & I_valid &
                  ((I_rs1 == rd_q) | (I_rs2 == rd_q));
  assign O_ready = (~valid_q | I_ready) & ~hazard & ~I_flush;
  assign accept  = I_valid & O_ready;

  // A nonzero destination is required, so index 0 can never match.
  assign exmem_hit1 = I_exmem_valid & I_exmem_wen & (I_exmem_rd != '0) & (I_exmem_rd == rs1_q);
  assign exmem_hit2 = I_exmem_valid & I_exmem_wen & (I_exmem_rd != '0) & (I_exmem_rd == rs2_q);
  assign memwb_hit1 = I_memwb_valid & I_memwb_wen & (I_memwb_rd != '0) & (I_memwb_rd == rs1_q);
  assign memwb_hit2 = I_memwb_valid & I_memwb_wen & (I_memwb_rd != '0) & (I_memwb_rd == rs2_q);
  assign byp_hit1   = I_memwb_valid & I_memwb_wen & (I_memwb_rd != '0) & (I_memwb_rd == I_rs1);
  assign byp_hit2   = I_memwb_valid & I_memwb_wen & (I_memwb_rd != '0) & (I_memwb_rd == I_rs2);

  always_comb begin
    fwd1 = rs1_data_q;
    fwd2 = rs2_data_q;
    if (memwb_hit1) fwd1 = I_memwb_data;
    if (exmem_hit1) fwd1 = I_exmem_data;
    if (memwb_hit2) fwd2 = I_memwb_data;
    if (exmem_hit2) fwd2 = I_exmem_data;
  end

  // Bypass a register-file write happening in the same cycle as the read.
  assign cap1 = byp_hit1 ? I_memwb_data : I_rs1_data;
  assign cap2 = byp_hit2 ? I_memwb_data : I_rs2_data;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      valid_q    <= 1'b0;
      wen_q      <= 1'b0;
      is_load_q  <= 1'b0;
      use_imm_q  <= 1'b0;
      use_pc_q   <= 1'b0;
      alusel_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else if (I_flush) begin
      valid_q <= 1'b0;
    end else if (~valid_q | I_ready) begin
      valid_q <= accept;
      if (accept) begin
        wen_q      <= I_wen;
        is_load_q  <= I_is_load;
        use_imm_q  <= I_use_imm;
        use_pc_q   <= I_use_pc;
        alusel_q   <= I_alusel;
        rs1_q      <= I_rs1;
        rs2_q      <= I_rs2;
        rd_q       <= I_rd;
        rs1_data_q <= cap1;
        rs2_data_q <= cap2;
        imm_q      <= I_imm;
        pc_q       <= I_pc;
      end
    end else begin
      // Recapture while stalled so a producer retiring from MEM/WB is not lost.
      rs1_data_q <= fwd1;
      rs2_data_q <= fwd2;
    end
  end

  assign O_valid      = valid_q;
  assign O_alusel     = alusel_q;
  assign O_rd         = rd_q;
  assign O_wen        = valid_q & wen_q;
  assign O_is_load    = valid_q & is_load_q;
  assign O_data1      = use_pc_q ? pc_q : fwd1;
  assign O_data2      = use_imm_q ? imm_q : fwd2;
  assign O_store_data = fwd2;

endmodule
